muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states, counter sizing and the sign-fixup negate.
package muldiv_pkg;

   // Default operand / HI / LO width.
   localparam int WIDTH_DEFAULT = 32;

   // Working width of the conditional negate; covers 2*WIDTH for WIDTH <= 64.
   localparam int NEG_W = 128;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } state_e;

   // Iteration counter width: counts 0 .. WIDTH-1.
   function automatic int cnt_width(input int w);
      cnt_width = $clog2(w);
   endfunction

   // Two's complement negate when en is set. Callers zero-extend into NEG_W
   // and truncate the result; the low bits of a negate do not depend on the
   // high bits, so truncation yields the correct narrower negate.
   function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v,
                                                 input logic             en);
      if (en) begin
         cond_neg = ~v + NEG_W'(1);
      end else begin
         cond_neg = v;
      end
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes.
// Owns the HI/LO registers; one operation per start, cancellable by flush.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam int W2    = 2 * WIDTH;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d;       // {partial/remainder, multiplier/quotient}
   logic [WIDTH-1:0] b_q, b_d;           // multiplicand / divisor magnitude
   logic             is_div_q, is_div_d;
   logic             neg_lo_q, neg_lo_d; // negate product or quotient
   logic             neg_hi_q, neg_hi_d; // negate remainder
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dbz_pls_q, dbz_pls_d;
   logic             busy_q, busy_d;

   op_e              op_s;
   logic             is_div_s, is_signed_s, sign_a_s, sign_b_s;
   logic [WIDTH-1:0] mag_a_s, mag_b_s;
   logic [WIDTH:0]   mul_sum_s, div_rem_s, div_diff_s;
   logic [W2-1:0]    mul_next_s, div_next_s, prod_fix_s;
   logic [WIDTH-1:0] quot_fix_s, rem_fix_s;

   // Operand decode and magnitudes taken at start.
   always_comb begin
      op_s        = op_e'(op);
      is_div_s    = (op_s == OP_DIV) || (op_s == OP_DIVU);
      is_signed_s = (op_s == OP_MULT) || (op_s == OP_DIV);
      sign_a_s    = is_signed_s & opA[WIDTH-1];
      sign_b_s    = is_signed_s & opB[WIDTH-1];
      mag_a_s     = WIDTH'(cond_neg(NEG_W'(opA), sign_a_s));
      mag_b_s     = WIDTH'(cond_neg(NEG_W'(opB), sign_b_s));
   end

   // One radix-2 step of each algorithm plus the final sign-corrected results.
   always_comb begin
      mul_sum_s  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, b_q};
      if (acc_q[0]) begin
         mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
      end else begin
         mul_next_s = {1'b0, acc_q[W2-1:1]};
      end
      div_rem_s  = acc_q[W2-1:WIDTH-1];
      div_diff_s = div_rem_s - {1'b0, b_q};
      if (div_rem_s >= {1'b0, b_q}) begin
         div_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next_s = {div_rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
      prod_fix_s = W2'(cond_neg(NEG_W'(acc_q), neg_lo_q));
      quot_fix_s = WIDTH'(cond_neg(NEG_W'(acc_q[WIDTH-1:0]), neg_lo_q));
      rem_fix_s  = WIDTH'(cond_neg(NEG_W'(acc_q[W2-1:WIDTH]), neg_hi_q));
   end

   // Controller next state and datapath register updates.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      b_d       = b_q;
      is_div_d  = is_div_q;
      neg_lo_d  = neg_lo_q;
      neg_hi_d  = neg_hi_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_pls_d = 1'b0;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         dbz_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  acc_d    = {{WIDTH{1'b0}}, mag_a_s};
                  b_d      = mag_b_s;
                  is_div_d = is_div_s;
                  neg_lo_d = sign_a_s ^ sign_b_s;
                  neg_hi_d = is_div_s & sign_a_s;
                  cnt_d    = '0;
                  if (is_div_s && (opB == {WIDTH{1'b0}})) begin
                     dbz_d   = 1'b1;
                     state_d = FIX;
                  end else begin
                     dbz_d   = 1'b0;
                     state_d = CALC;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            CALC: begin
               if (is_div_q) begin
                  acc_d = div_next_s;
               end else begin
                  acc_d = mul_next_s;
               end
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  cnt_d   = '0;
                  state_d = FIX;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            FIX: begin
               state_d   = IDLE;
               done_d    = 1'b1;
               dbz_pls_d = dbz_q;
               if (dbz_q) begin
                  hi_d = hi_q;
               end else if (is_div_q) begin
                  hi_d = rem_fix_s;
                  lo_d = quot_fix_s;
               end else begin
                  hi_d = prod_fix_s[W2-1:WIDTH];
                  lo_d = prod_fix_s[WIDTH-1:0];
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         is_div_q  <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_pls_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         is_div_q  <= is_div_d;
         neg_lo_q  <= neg_lo_d;
         neg_hi_q  <= neg_hi_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_pls_q <= dbz_pls_d;
         busy_q    <= busy_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_pls_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a behavioural model (plain 64-bit
// arithmetic plus a latency countdown) checked every cycle, directed cases
// with literal expectations, then randomized traffic.
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  opA, opB;
   logic          flush;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int tests  = 0;
   int failed = 0;
   bit check_en = 1'b0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
      .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Literal comparison helper.
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference result from plain arithmetic on the architectural operands.
   function automatic void model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] h, output logic [W-1:0] l, output bit dz);
      logic signed [63:0] sa, sb, sp, sq, sr;
      logic [63:0]        ua, ub, up, uq, ur;
      sa = {{32{a[W-1]}}, a};
      sb = {{32{b[W-1]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      dz = 1'b0;
      h  = 32'd0;
      l  = 32'd0;
      case (o)
         2'b00: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
         2'b01: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
         2'b10: begin
            if (b == 32'd0) dz = 1'b1;
            else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
         end
         default: begin
            if (b == 32'd0) dz = 1'b1;
            else begin uq = ua / ub; ur = ua % ub; l = uq[31:0]; h = ur[31:0]; end
         end
      endcase
   endfunction

   // Behavioural model: remaining cycles of the accepted operation.
   int           rem_m = 0;
   logic [W-1:0] exp_hi = 32'd0, exp_lo = 32'd0, pend_hi, pend_lo;
   bit           exp_done = 1'b0, exp_dbz = 1'b0, pend_dbz;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_m = 0; exp_hi = 32'd0; exp_lo = 32'd0; exp_done = 1'b0; exp_dbz = 1'b0;
      end else begin
         exp_done = 1'b0;
         exp_dbz  = 1'b0;
         if (flush) begin
            rem_m = 0;
         end else if (rem_m == 0) begin
            if (start) begin
               model_op(op, opA, opB, pend_hi, pend_lo, pend_dbz);
               rem_m = pend_dbz ? 1 : W + 1;
            end
         end else begin
            rem_m--;
            if (rem_m == 0) begin
               exp_done = 1'b1;
               exp_dbz  = pend_dbz;
               if (!pend_dbz) begin exp_hi = pend_hi; exp_lo = pend_lo; end
            end
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (check_en && !reset) begin
         tests++;
         if (busy !== (rem_m > 0) || done !== exp_done || div_by_zero !== exp_dbz ||
             hi !== exp_hi || lo !== exp_lo) begin
            failed++;
            $display("FAIL cycle@%0t: got busy=%b done=%b dbz=%b hi=%h lo=%h expected busy=%b done=%b dbz=%b hi=%h lo=%h",
                     $time, busy, done, div_by_zero, hi, lo, (rem_m > 0), exp_done, exp_dbz, exp_hi, exp_lo);
         end
      end
   end

   // Count edges after the start-sampling edge until done, bounded.
   task automatic wait_done(input int first, output int edges);
      edges = first;
      while (edges < 200) begin
         @(posedge clk); edges++; #1;
         if (done) break;
      end
      if (!done) chk("timeout", {31'd0, done}, 32'd1);
   endtask

   // Issue one operation (called 1 time unit after an edge) and wait for done.
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int edges);
      op = o; opA = a; opB = b; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(0, edges);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: pick = 32'd0;
         1: pick = 32'd1;
         2: pick = 32'hFFFF_FFFF;
         3: pick = 32'h8000_0000;
         4: pick = 32'($urandom_range(0, 15));
         default: pick = $urandom();
      endcase
   endfunction

   int e;
   logic [W-1:0] mdl_h, mdl_l;
   bit mdl_dz;

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; opA = 32'd0; opB = 32'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_en = 1'b1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);

      // Model pinned against hand-computed values.
      model_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mdl_h, mdl_l, mdl_dz);
      chk("model_ovf_lo", mdl_l, 32'h8000_0000);
      chk("model_ovf_hi", mdl_h, 32'd0);
      model_op(2'b00, 32'hFFFF_FFFE, 32'd3, mdl_h, mdl_l, mdl_dz);
      chk("model_mult_lo", mdl_l, 32'hFFFF_FFFA);

      // Signed multiply: latency WIDTH+1 edges after the sampling edge.
      do_op(2'b00, 32'hFFFF_FFFF, 32'd7, e);
      chk("mult_lat", 32'(e), 32'd33);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFF9);
      chk("mult_busy_at_done", {31'd0, busy}, 32'd0);

      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);

      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, e);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      do_op(2'b11, 32'd7, 32'd2, e);
      chk("divu_lo", lo, 32'd3);
      chk("divu_hi", hi, 32'd1);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, e);
      chk("div_ovf_lo", lo, 32'h8000_0000);
      chk("div_ovf_hi", hi, 32'd0);

      // Divide by zero: done one edge after the sampling edge, HI/LO kept.
      do_op(2'b11, 32'h0000_2211, 32'h0000_0100, e);
      chk("prep_hi", hi, 32'h11);
      chk("prep_lo", lo, 32'h22);
      do_op(2'b10, 32'd5, 32'd0, e);
      chk("dbz_lat", 32'(e), 32'd1);
      chk("dbz_flag", {31'd0, div_by_zero}, 32'd1);
      chk("dbz_hi", hi, 32'h11);
      chk("dbz_lo", lo, 32'h22);
      @(posedge clk); #1;
      chk("dbz_pulse_len", {31'd0, div_by_zero}, 32'd0);

      // Flush at the tenth edge after the sampling edge.
      op = 2'b00; opA = 32'd3; opB = 32'd4; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("flush_hi", hi, 32'h11);
      chk("flush_lo", lo, 32'h22);
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      chk("start_flush_busy", {31'd0, busy}, 32'd0);

      // Start while busy is ignored; start in the done cycle is accepted.
      op = 2'b00; opA = 32'd3; opB = 32'd4; start = 1'b1;
      @(posedge clk); #1 op = 2'b01; opA = 32'd5; opB = 32'd5;
      @(posedge clk); #1 start = 1'b0;
      wait_done(1, e);
      chk("b2b_first_lat", 32'(e), 32'd33);
      chk("b2b_first_lo", lo, 32'd12);
      chk("b2b_first_hi", hi, 32'd0);
      do_op(2'b01, 32'd6, 32'd7, e);
      chk("b2b_second_lat", 32'(e), 32'd33);
      chk("b2b_second_lo", lo, 32'd42);

      // Asynchronous reset in the middle of a divide.
      op = 2'b11; opA = 32'd100; opB = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 299) == 0);
         op    = 2'($urandom_range(0, 3));
         opA   = pick();
         opB   = pick();
      end
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
